// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: dual-rail bipolar symbols in, NRZ data out.
// Strips B00V / 000V substitutions and flags line-code errors.
module hdb3_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_p,
    input  logic                 i_n,
    output logic                 o_data,
    output logic                 o_sync,
    output logic                 o_err_bip,
    output logic                 o_err_viol,
    output logic                 o_err_zero,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    // sampled symbol, processed one cycle after it is taken
    logic       p_q;
    logic       n_q;

    // nonzero history: [0] = previous symbol, [1] = the one before
    logic [1:0] nz_q;

    // decoded bits in flight; d3 is the oldest and may still be retracted
    logic       d1;
    logic       d2;
    logic       d3;

    // polarity tracking, 1 = positive
    logic       last_pol;
    logic       last_v_pol;
    logic       seen_mark;
    logic       seen_v;
    logic [2:0] zero_run;

    logic       is_bip;
    logic       nonzero;
    logic       pol;
    logic       is_v;
    logic       is_mark;
    logic       viol;
    logic       zero_hit;
    logic       any_err;

    // classify the sampled symbol and decide mark / violation
    always_comb begin
        is_bip   = p_q & n_q;
        nonzero  = p_q ^ n_q;
        pol      = p_q;
        is_v     = nonzero & seen_mark & (pol == last_pol);
        is_mark  = nonzero & ~is_v;
        viol     = is_v & ((|nz_q) | (seen_v & (pol == last_v_pol)));
        zero_hit = ~nonzero & seen_mark & (zero_run == 3'd3);
        any_err  = is_bip | viol | zero_hit;
    end

    // input sampling register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            p_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            p_q <= i_p;
            n_q <= i_n;
        end
    end

    // data delay line; a V zeroes the B three symbols back
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            d1     <= 1'b0;
            d2     <= 1'b0;
            d3     <= 1'b0;
            o_data <= 1'b0;
            nz_q   <= 2'b00;
        end else begin
            d1     <= is_mark;
            d2     <= d1;
            d3     <= d2;
            o_data <= is_v ? 1'b0 : d3;
            nz_q   <= {nz_q[0], nonzero};
        end
    end

    // polarity, sync and zero-run tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_pol   <= 1'b0;
            last_v_pol <= 1'b0;
            seen_mark  <= 1'b0;
            seen_v     <= 1'b0;
            zero_run   <= 3'd0;
        end else begin
            if (is_mark) begin
                last_pol <= pol;
            end
            if (nonzero) begin
                seen_mark <= 1'b1;
            end
            if (is_v) begin
                last_v_pol <= pol;
                seen_v     <= 1'b1;
            end
            if (nonzero) begin
                zero_run <= 3'd0;
            end else if (zero_run != 3'd4) begin
                zero_run <= zero_run + 3'd1;
            end
        end
    end

    assign o_sync = seen_mark;

    // one-cycle error pulses and the saturating error counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_bip  <= 1'b0;
            o_err_viol <= 1'b0;
            o_err_zero <= 1'b0;
            o_err_cnt  <= '0;
        end else begin
            o_err_bip  <= is_bip;
            o_err_viol <= viol;
            o_err_zero <= zero_hit;
            if (any_err && (o_err_cnt != {ERR_CNT_W{1'b1}})) begin
                o_err_cnt <= o_err_cnt + 1'b1;
            end
        end
    end

endmodule
